// File: rtl/inst_fetch_pkg.sv
// ----------------------------------------------------------------------------
// inst_fetch_pkg
//   Shared constants and types for the instruction-fetch front end.
//   RESET_PC   : byte address fetched first after reset
//   ROM_BYTES  : ROM capacity in bytes; fetches at or above it are flagged
//   INST_NOP   : value driven on inst_o whenever no instruction is valid
//   fetch_state_t : RUN (streaming from ROM) / HOLD (replaying a stalled word)
// ----------------------------------------------------------------------------
package inst_fetch_pkg;

    localparam logic [31:0] RESET_PC  = 32'h0000_0000;
    localparam int unsigned ROM_BYTES = 4096;
    localparam logic [31:0] INST_NOP  = 32'h0000_0000;

    typedef enum logic {
        RUN  = 1'b0,
        HOLD = 1'b1
    } fetch_state_t;

endpackage

// File: rtl/inst_fetch_hold_reg.sv
// ----------------------------------------------------------------------------
// fetch_hold_reg
//   Capture register for an instruction that decode refused, plus the output
//   mux choosing between the held word and the live ROM response.
//   Ports:
//     clk, rst_n     : clock, asynchronous active-low reset
//     i_capture      : latch i_rom_inst/i_resp_pc into the hold register
//     i_clear        : discard the held word (redirect)
//     i_hold_sel     : present the held word instead of the ROM response
//     i_squash       : force the output invalid this cycle
//     i_resp_ok      : the ROM response is tagged valid
//     i_resp_pc      : byte address of the word on i_rom_inst
//     i_rom_inst     : ROM read data
//     o_pc / o_inst  : selected pc/instruction, zero when not valid
//     o_valid        : o_pc/o_inst meaningful this cycle
// ----------------------------------------------------------------------------
module fetch_hold_reg
    import inst_fetch_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic        i_capture,
    input  logic        i_clear,
    input  logic        i_hold_sel,
    input  logic        i_squash,
    input  logic        i_resp_ok,
    input  logic [31:0] i_resp_pc,
    input  logic [31:0] i_rom_inst,
    output logic [31:0] o_pc,
    output logic [31:0] o_inst,
    output logic        o_valid
);

    logic [31:0] r_hold_inst;
    logic [31:0] r_hold_pc;
    logic        w_valid;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_hold_inst <= '0;
            r_hold_pc   <= '0;
        end else if (i_clear) begin
            r_hold_inst <= '0;
            r_hold_pc   <= '0;
        end else if (i_capture) begin
            r_hold_inst <= i_rom_inst;
            r_hold_pc   <= i_resp_pc;
        end
    end

    always_comb begin
        w_valid = !i_squash && (i_hold_sel || i_resp_ok);
        o_valid = w_valid;
        o_pc    = '0;
        o_inst  = INST_NOP;
        if (w_valid) begin
            o_pc   = i_hold_sel ? r_hold_pc   : i_resp_pc;
            o_inst = i_hold_sel ? r_hold_inst : i_rom_inst;
        end
    end

endmodule

// File: rtl/inst_fetch.sv
// ----------------------------------------------------------------------------
// inst_fetch
//   Instruction-fetch front end. Drives the word address of an external
//   registered-output instruction ROM and turns its responses into a
//   pc/inst/valid stream for decode, with stall back-pressure and branch
//   redirect. A word that arrives while decode stalls is parked in a hold
//   register so it is neither lost nor re-fetched.
//   Ports:
//     clk, rst_n    : clock, asynchronous active-low reset
//     stall         : decode not accepting inst_o this cycle
//     redirect      : squash current word, refetch from redirect_pc
//     redirect_pc   : target byte address (bits [1:0] ignored)
//     rom_addr      : ROM word index for the next read
//     rom_inst      : ROM data for the address presented on the previous edge
//     pc_o, inst_o  : byte address and instruction (zero when not valid)
//     inst_valid    : pc_o/inst_o meaningful
//     inst_err      : valid word fetched at or above ROM_BYTES
// ----------------------------------------------------------------------------
module inst_fetch #(
    parameter logic [31:0] RESET_PC  = inst_fetch_pkg::RESET_PC,
    parameter int unsigned ROM_BYTES = inst_fetch_pkg::ROM_BYTES
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        stall,
    input  logic        redirect,
    input  logic [31:0] redirect_pc,
    output logic [31:0] rom_addr,
    input  logic [31:0] rom_inst,
    output logic [31:0] pc_o,
    output logic [31:0] inst_o,
    output logic        inst_valid,
    output logic        inst_err
);

    import inst_fetch_pkg::*;

    fetch_state_t r_state;
    fetch_state_t w_state_nxt;

    logic [31:0] r_fetch_pc;
    logic [31:0] r_resp_pc;
    logic        r_resp_ok;

    logic [31:0] w_target;
    logic [31:0] w_pc;
    logic [31:0] w_inst;
    logic        w_valid;
    logic        w_hold_sel;
    logic        w_capture;
    logic        w_advance;
    logic        w_unused_rpc_lsb;

    // Word alignment: the byte offset of a branch target is dropped.
    assign w_target         = {redirect_pc[31:2], 2'b00};
    assign w_unused_rpc_lsb = ^redirect_pc[1:0];

    // The ROM registers this address on the coming edge, so the word it
    // returns next cycle belongs to whatever resp_pc is loaded with.
    assign rom_addr = {2'b00, (redirect ? w_target[31:2] : r_fetch_pc[31:2])};

    // ---------------- FSM: state register ----------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= RUN;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // ---------------- FSM: next state ----------------
    always_comb begin
        w_state_nxt = r_state;
        if (redirect) begin
            w_state_nxt = RUN;
        end else if (r_state == RUN) begin
            if (stall && w_valid) begin
                w_state_nxt = HOLD;
            end
        end else begin
            if (!stall) begin
                w_state_nxt = RUN;
            end
        end
    end

    // ---------------- FSM: outputs / datapath controls ----------------
    // Advancing means the word on the output is consumed (or there was none),
    // so the next sequential address can be requested.
    always_comb begin
        w_hold_sel = (r_state == HOLD);
        w_capture  = 1'b0;
        w_advance  = 1'b0;
        if (!redirect) begin
            if (r_state == RUN) begin
                w_capture = stall && w_valid;
                w_advance = !(stall && w_valid);
            end else begin
                w_advance = !stall;
            end
        end
    end

    // In HOLD with stall nothing moves: the ROM keeps re-reading fetch_pc, and
    // resp_pc already equals fetch_pc, so on release the live response is
    // exactly the next word in sequence.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_fetch_pc <= RESET_PC;
            r_resp_pc  <= '0;
            r_resp_ok  <= 1'b0;
        end else if (redirect) begin
            r_fetch_pc <= w_target + 32'd4;
            r_resp_pc  <= w_target;
            r_resp_ok  <= 1'b1;
        end else if (w_advance) begin
            r_fetch_pc <= r_fetch_pc + 32'd4;
            r_resp_pc  <= r_fetch_pc;
            r_resp_ok  <= 1'b1;
        end else if (w_capture) begin
            r_resp_pc  <= r_fetch_pc;
            r_resp_ok  <= 1'b1;
        end
    end

    fetch_hold_reg u_hold (
        .clk        (clk),
        .rst_n      (rst_n),
        .i_capture  (w_capture),
        .i_clear    (redirect),
        .i_hold_sel (w_hold_sel),
        .i_squash   (redirect),
        .i_resp_ok  (r_resp_ok),
        .i_resp_pc  (r_resp_pc),
        .i_rom_inst (rom_inst),
        .o_pc       (w_pc),
        .o_inst     (w_inst),
        .o_valid    (w_valid)
    );

    assign pc_o       = w_pc;
    assign inst_o     = w_inst;
    assign inst_valid = w_valid;
    assign inst_err   = w_valid && (w_pc >= ROM_BYTES);

endmodule
